sb_lfosc: RTL and testbench

// - Synthesizable behavioural model of the iCE40 low-frequency oscillator (LFOSC, nominal 10 kHz).
// - Derives CLKLF from the fabric reference clock sysclk using a power-up delay, a half-period divider and a glitch-free enable gate.
// - Replaces the hard primitive in simulation and on targets without one. It feeds slow housekeeping logic (LED/CPU tick domain).

---
 rtl/sb_lfosc_pkg.sv | 15 +
 rtl/lfosc_glitchless_gate.sv | 31 +++
 rtl/sb_lfosc.sv | 109 ++++++++++
 tb/tb_sb_lfosc.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/sb_lfosc_pkg.sv
// Shared types and helpers for the behavioural iCE40 low-frequency oscillator.
package sb_lfosc_pkg;

  typedef enum logic [1:0] {
    OFF      = 2'd0,
    STARTING = 2'd1,
    RUN      = 2'd2
  } lfosc_state_e;

  // Half-period in sysclk cycles; odd remainders are intentionally truncated.
  function automatic int calc_half(input int sysclk_hz, input int lf_hz);
    return sysclk_hz / (2 * lf_hz);
  endfunction

endpackage

// File: rtl/lfosc_glitchless_gate.sv
// Enable gate for the LF clock: the enable is only sampled while the oscillator is low.
module lfosc_glitchless_gate (
  input  logic clk_i,
  input  logic reset_i,
  input  logic osc_next_i,
  input  logic en_i,
  output logic gated_o
);

  logic gate_q;
  logic gate_d;
  logic out_q;

  // Holding the gate during the high phase means an enable drop never clips a pulse.
  always_comb begin
    gate_d = osc_next_i ? gate_q : en_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      gate_q <= 1'b0;
      out_q  <= 1'b0;
    end else begin
      gate_q <= gate_d;
      out_q  <= osc_next_i & gate_d;
    end
  end

  assign gated_o = out_q;

endmodule

// File: rtl/sb_lfosc.sv
// Behavioural LFOSC: power-up delay, half-period divider and glitch-free enable
// producing CLKLF from sysclk.
module sb_lfosc
  import sb_lfosc_pkg::*;
#(
  parameter int SYSCLK_HZ    = 48_000_000,
  parameter int LF_HZ        = 10_000,
  parameter int PU_DELAY_CYC = 4_800
) (
  input  logic sysclk,
  input  logic reset,
  input  logic CLKLFPU,
  input  logic CLKLFEN,
  output logic CLKLF
);

  localparam int HALF = calc_half(SYSCLK_HZ, LF_HZ);
  localparam int PU_W = (PU_DELAY_CYC > 1) ? $clog2(PU_DELAY_CYC) : 1;
  localparam int HC_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [PU_W-1:0] PU_LAST   = PU_W'(PU_DELAY_CYC - 1);
  localparam logic [HC_W-1:0] HALF_LAST = HC_W'(HALF - 1);

  if (HALF < 1) begin : g_bad_half
    $error("sb_lfosc: SYSCLK_HZ/(2*LF_HZ) must be at least 1");
  end
  if (PU_DELAY_CYC < 1) begin : g_bad_pu
    $error("sb_lfosc: PU_DELAY_CYC must be at least 1");
  end

  lfosc_state_e    state_q, state_d;
  logic [PU_W-1:0] pu_cnt_q, pu_cnt_d;
  logic [HC_W-1:0] half_cnt_q, half_cnt_d;
  logic            osc_q, osc_d;

  always_comb begin
    state_d    = state_q;
    pu_cnt_d   = pu_cnt_q;
    half_cnt_d = half_cnt_q;
    osc_d      = osc_q;
    if (!CLKLFPU) begin
      // Power-down wins from any state, even mid high phase.
      state_d    = OFF;
      pu_cnt_d   = '0;
      half_cnt_d = '0;
      osc_d      = 1'b0;
    end else begin
      unique case (state_q)
        OFF: begin
          half_cnt_d = '0;
          osc_d      = 1'b0;
          if (PU_DELAY_CYC == 1) begin
            state_d  = RUN;
            pu_cnt_d = '0;
          end else begin
            state_d  = STARTING;
            pu_cnt_d = PU_W'(1);
          end
        end
        STARTING: begin
          if (pu_cnt_q == PU_LAST) begin
            state_d    = RUN;
            pu_cnt_d   = '0;
            half_cnt_d = '0;
            osc_d      = 1'b0;
          end else begin
            pu_cnt_d = pu_cnt_q + PU_W'(1);
          end
        end
        RUN: begin
          if (half_cnt_q == HALF_LAST) begin
            half_cnt_d = '0;
            osc_d      = ~osc_q;
          end else begin
            half_cnt_d = half_cnt_q + HC_W'(1);
          end
        end
        default: begin
          state_d    = OFF;
          pu_cnt_d   = '0;
          half_cnt_d = '0;
          osc_d      = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q    <= OFF;
      pu_cnt_q   <= '0;
      half_cnt_q <= '0;
      osc_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pu_cnt_q   <= pu_cnt_d;
      half_cnt_q <= half_cnt_d;
      osc_q      <= osc_d;
    end
  end

  lfosc_glitchless_gate u_gate (
    .clk_i      (sysclk),
    .reset_i    (reset),
    .osc_next_i (osc_d),
    .en_i       (CLKLFEN),
    .gated_o    (CLKLF)
  );

endmodule

// File: tb/tb_sb_lfosc.sv
// Directed bench for sb_lfosc with HALF=5 and an 8-cycle power-up delay.
module tb_sb_lfosc;
  import sb_lfosc_pkg::*;

  logic sysclk;
  logic reset;
  logic CLKLFPU;
  logic CLKLFEN;
  logic CLKLF;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic  rst;
    logic  pu;
    logic  en;
    logic  exp_clk;
    string tag;
  } vec_t;

  vec_t vq[$];

  sb_lfosc #(
    .SYSCLK_HZ    (100),
    .LF_HZ        (10),
    .PU_DELAY_CYC (8)
  ) dut (
    .sysclk  (sysclk),
    .reset   (reset),
    .CLKLFPU (CLKLFPU),
    .CLKLFEN (CLKLFEN),
    .CLKLF   (CLKLF)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic add(input logic r, input logic p, input logic e, input logic x,
                     input int n, input string tag);
    vec_t v;
    v.rst = r; v.pu = p; v.en = e; v.exp_clk = x; v.tag = tag;
    for (int k = 0; k < n; k++) vq.push_back(v);
  endtask

  // Drive one record per edge, sample 1 time unit after the edge.
  task automatic run_table();
    int idx;
    vec_t v;
    idx = 0;
    while (vq.size() > 0) begin
      v = vq.pop_front();
      reset   = v.rst;
      CLKLFPU = v.pu;
      CLKLFEN = v.en;
      @(posedge sysclk);
      #1;
      checks++;
      if (CLKLF !== v.exp_clk) begin
        failures++;
        $display("FAIL %s[%0d] CLKLF got=%b exp=%b", v.tag, idx, CLKLF, v.exp_clk);
      end
      idx++;
    end
  endtask

  task automatic check_state(input lfosc_state_e exp_st, input string tag);
    checks++;
    if (dut.state_q !== exp_st) begin
      failures++;
      $display("FAIL %s state got=%0d exp=%0d", tag, dut.state_q, exp_st);
    end
  endtask

  initial begin
    reset   = 1'b1;
    CLKLFPU = 1'b1;
    CLKLFEN = 1'b1;
    #2;

    // Reset held 3 edges with PU/EN high.
    add(1, 1, 1, 0, 3, "reset");
    run_table();
    check_state(OFF, "reset_state");

    // Startup: first rise at edge 13, then 5 high / 5 low.
    add(0, 1, 1, 0, 12, "startup_low");
    add(0, 1, 1, 1, 5,  "run_hi1");
    add(0, 1, 1, 0, 5,  "run_lo1");
    add(0, 1, 1, 1, 5,  "run_hi2");
    add(0, 1, 1, 0, 5,  "run_lo2");
    // EN dropped 2 cycles into a high phase: pulse completes, next pulse suppressed.
    add(0, 1, 1, 1, 2,  "en_drop_pre");
    add(0, 1, 0, 1, 3,  "en_drop_hold");
    add(0, 1, 0, 0, 12, "en_off");
    // EN raised mid low phase: next rise is output on schedule.
    add(0, 1, 1, 0, 3,  "en_rise_lo");
    add(0, 1, 1, 1, 5,  "en_rise_hi");
    add(0, 1, 1, 0, 5,  "en_rise_lo2");
    // PU dropped mid high phase, then reasserted.
    add(0, 1, 1, 1, 2,  "pu_drop_pre");
    add(0, 0, 1, 0, 2,  "pu_off");
    add(0, 1, 1, 0, 12, "pu_restart_low");
    add(0, 1, 1, 1, 5,  "pu_restart_hi");
    add(0, 1, 1, 0, 5,  "pu_restart_lo");
    add(0, 1, 1, 1, 2,  "pre_reset_hi");
    // Reset during a high phase, then full restart.
    add(1, 1, 1, 0, 2,  "reset_in_run");
    add(0, 1, 1, 0, 12, "rst_restart_low");
    add(0, 1, 1, 1, 5,  "rst_restart_hi");
    add(0, 1, 1, 0, 3,  "rst_restart_lo");
    run_table();

    // PU low for 50 cycles: output and state must stay idle.
    for (int i = 0; i < 50; i++) begin
      reset   = 1'b0;
      CLKLFPU = 1'b0;
      CLKLFEN = 1'b1;
      @(posedge sysclk);
      #1;
      checks++;
      if (CLKLF !== 1'b0) begin
        failures++;
        $display("FAIL pu_low[%0d] CLKLF got=%b exp=0", i, CLKLF);
      end
      check_state(OFF, "pu_low");
    end

    // Power-up delay boundary: STARTING after 7 edges, RUN exactly after the 8th.
    CLKLFPU = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(posedge sysclk);
      #1;
    end
    check_state(STARTING, "pu_edge7");
    @(posedge sysclk);
    #1;
    check_state(RUN, "pu_edge8");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
